// File: rtl/axi_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter_if
// Bundles the request/grant signals of one AXI address-channel arbiter.
//   req          per-master request (master VALID)
//   handshake    VALID & READY on the granted master's channel this cycle
//   grant        one-hot grant, all-zero when nothing is granted
//   grant_idx    index of the granted master (0 when grant_valid = 0)
//   grant_valid  OR of grant
// Modports:
//   master : the requesting side (drives req/handshake, observes grant)
//   slave  : the arbiter itself (observes req/handshake, drives grant)
// ---------------------------------------------------------------------------
interface axi_rr_arbiter_if #(
    parameter int NUM_M = 4
);
    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    logic [NUM_M-1:0] req;
    logic             handshake;
    logic [NUM_M-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    modport master (
        output req,
        output handshake,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        input  handshake,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
// N-master round-robin arbiter for one AXI address channel (AR or AW).
// A rotating priority pointer picks the first requester at or after rr_ptr.
// With LOCK_EN=1 the winner is held from its first grant until its
// handshake, so a granted VALID is never withdrawn by re-arbitration.
// The grant is combinational from req; pointer and lock state are registered.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active-low (forces grant to zero)
//   arb    slave modport of axi_rr_arbiter_if (req, handshake in;
//          grant, grant_idx, grant_valid out)
// ---------------------------------------------------------------------------
module axi_rr_arbiter #(
    parameter int NUM_M   = 4,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_rr_arbiter_if.slave        arb
);
    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] rr_ptr_nxt_s;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] lock_idx_nxt_s;

    logic             win_found_s;
    logic [IDX_W-1:0] win_idx_s;

    logic [NUM_M-1:0] grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_valid_s;

    // Successor index modulo NUM_M; wraps explicitly so non-power-of-2 counts work.
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt_v;
        if (int'(idx) >= NUM_M - 1) begin
            nxt_v = '0;
        end else begin
            nxt_v = idx + IDX_W'(1'b1);
        end
        return nxt_v;
    endfunction

    // Decode an index into a one-hot request-width vector.
    function automatic logic [NUM_M-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_M-1:0] vec_v;
        vec_v      = '0;
        vec_v[idx] = 1'b1;
        return vec_v;
    endfunction

    // Round-robin scan: first requester at rr_ptr, rr_ptr+1, ... (mod NUM_M).
    always_comb begin
        int               cand_v;
        logic [IDX_W-1:0] cand_idx_v;
        logic             hit_v;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_v      = 0;
        cand_idx_v  = '0;
        hit_v       = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            cand_v      = (int'(rr_ptr_r) + k) % NUM_M;
            cand_idx_v  = IDX_W'(cand_v);
            hit_v       = arb.req[cand_idx_v] & ~win_found_s;
            win_idx_s   = hit_v ? cand_idx_v : win_idx_s;
            win_found_s = win_found_s | arb.req[cand_idx_v];
        end
    end

    // Next-state and grant decode for the IDLE/LOCKED controller.
    always_comb begin
        state_nxt_s    = state_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        lock_idx_nxt_s = lock_idx_r;
        grant_s        = '0;
        grant_idx_s    = '0;
        grant_valid_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_s       = onehot(win_idx_s);
                    grant_idx_s   = win_idx_s;
                    grant_valid_s = 1'b1;
                    if (arb.handshake) begin
                        rr_ptr_nxt_s = ptr_after(win_idx_s);
                    end else if (LOCK_EN) begin
                        state_nxt_s    = ST_LOCKED;
                        lock_idx_nxt_s = win_idx_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    // Nothing requested: a stray handshake changes nothing.
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Held irrespective of req; a dropped req is a master protocol error.
                grant_s       = onehot(lock_idx_r);
                grant_idx_s   = lock_idx_r;
                grant_valid_s = 1'b1;
                if (arb.handshake) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = ptr_after(lock_idx_r);
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                rr_ptr_nxt_s   = '0;
                lock_idx_nxt_s = '0;
            end
        endcase
    end

    // Pointer, lock index and controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            lock_idx_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            lock_idx_r <= lock_idx_nxt_s;
        end
    end

    // Grant is zero-latency; reset masks it at once even mid-cycle.
    assign arb.grant       = rst_n ? grant_s       : '0;
    assign arb.grant_idx   = rst_n ? grant_idx_s   : '0;
    assign arb.grant_valid = rst_n ? grant_valid_s : 1'b0;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rr_arbiter
// Drives a 4-master locking arbiter and a 3-master non-locking arbiter with
// directed vectors. A queue-free reference (pointer + optional held index)
// predicts every cycle's outputs; hand-computed literals pin key points.
// ---------------------------------------------------------------------------
module tb_axi_rr_arbiter;
    logic clk;
    logic rst4_n;
    logic rst3_n;

    int n_tests;
    int n_fail;

    axi_rr_arbiter_if #(.NUM_M(4)) if4 ();
    axi_rr_arbiter_if #(.NUM_M(3)) if3 ();

    axi_rr_arbiter #(.NUM_M(4), .LOCK_EN(1'b1)) u_dut4 (
        .clk   (clk),
        .rst_n (rst4_n),
        .arb   (if4)
    );

    axi_rr_arbiter #(.NUM_M(3), .LOCK_EN(1'b0)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .arb   (if3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: first requester scanning ptr, ptr+1, ... modulo n, or -1.
    function automatic int pick(input int reqm, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (reqm[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    int  m_ptr  [2];
    bit  m_held [2];
    int  m_hidx [2];
    int  m_n    [2];
    bit  m_lock [2];

    // Per-cycle compare of both arbiters against the reference.
    initial begin
        int reqm, hs, rstv, ag, ai, av, eg, ei, ev, w;
        m_n[0] = 4; m_lock[0] = 1'b1;
        m_n[1] = 3; m_lock[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_held[d] = 1'b0; m_hidx[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    reqm = int'(if4.req); hs = int'(if4.handshake); rstv = int'(rst4_n);
                    ag = int'(if4.grant); ai = int'(if4.grant_idx); av = int'(if4.grant_valid);
                end else begin
                    reqm = int'(if3.req); hs = int'(if3.handshake); rstv = int'(rst3_n);
                    ag = int'(if3.grant); ai = int'(if3.grant_idx); av = int'(if3.grant_valid);
                end
                eg = 0; ei = 0; ev = 0;
                if (rstv == 0) begin
                    m_ptr[d] = 0; m_held[d] = 1'b0; m_hidx[d] = 0;
                end else if (m_held[d]) begin
                    eg = 1 << m_hidx[d]; ei = m_hidx[d]; ev = 1;
                    if (hs != 0) begin
                        m_held[d] = 1'b0;
                        m_ptr[d]  = (m_hidx[d] + 1) % m_n[d];
                    end
                end else begin
                    w = pick(reqm, m_ptr[d], m_n[d]);
                    if (w >= 0) begin
                        eg = 1 << w; ei = w; ev = 1;
                        if (hs != 0) begin
                            m_ptr[d] = (w + 1) % m_n[d];
                        end else if (m_lock[d]) begin
                            m_held[d] = 1'b1;
                            m_hidx[d] = w;
                        end
                    end
                end
                check($sformatf("model_grant_d%0d", d), ag, eg);
                check($sformatf("model_idx_d%0d", d), ai, ei);
                check($sformatf("model_valid_d%0d", d), av, ev);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq1 [6] = '{0, 1, 2, 3, 0, 1};
    int seq6 [4] = '{0, 1, 2, 0};

    // Directed stimulus with hand-computed expectations.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst4_n = 1'b0; rst3_n = 1'b0;
        if4.req = 4'b0000; if4.handshake = 1'b0;
        if3.req = 3'b000;  if3.handshake = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset forces zero grant whatever req says.
        if4.req = 4'b1111;
        #1;
        check("rst_grant", int'(if4.grant), 0);
        check("rst_valid", int'(if4.grant_valid), 0);
        check("rst_idx", int'(if4.grant_idx), 0);
        if4.req = 4'b0000;
        rst4_n = 1'b1; rst3_n = 1'b1;
        tick();

        // 1: all request, handshake every cycle -> 0,1,2,3,0,1 (ptr ends at 2).
        if4.req = 4'b1111; if4.handshake = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            check($sformatf("t1_idx%0d", i), int'(if4.grant_idx), seq1[i]);
            tick();
        end
        if4.req = 4'b0000; if4.handshake = 1'b0;
        tick();

        // 2: m2 granted and locked; m0 joining does not steal the grant.
        if4.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("t2_hold%0d", i), int'(if4.grant), 4'b0100);
            tick();
        end
        if4.req = 4'b0101;
        #2; check("t2_lock_vs_m0", int'(if4.grant), 4'b0100);
        tick();
        if4.handshake = 1'b1;
        #2; check("t2_hs_grant", int'(if4.grant), 4'b0100);
        tick();
        // rr_ptr=3, only m0/m2 requesting: scan wraps 3 -> 0.
        #2; check("t2_wrap", int'(if4.grant), 4'b0001);
        tick();  // handshake on m0 -> ptr=1

        // 3: grant m2 with handshake -> ptr=3; then req 1001 -> m3, then m0.
        if4.req = 4'b0100;
        #2; check("t3_m2", int'(if4.grant_idx), 2);
        tick();
        if4.req = 4'b1001; if4.handshake = 1'b0;
        #2; check("t3_m3", int'(if4.grant), 4'b1000);
        tick();
        if4.handshake = 1'b1;
        #2; check("t3_m3_held", int'(if4.grant_idx), 3);
        tick();
        #2; check("t3_m0", int'(if4.grant), 4'b0001);
        tick();  // ptr=1

        // 4: handshake with no request is ignored; ptr stays at 1.
        if4.req = 4'b0000;
        #2; check("t4_valid0", int'(if4.grant_valid), 0);
        check("t4_grant0", int'(if4.grant), 0);
        tick();
        tick();
        if4.req = 4'b1111;
        #2; check("t4_ptr_kept", int'(if4.grant_idx), 1);
        tick();  // ptr=2
        if4.req = 4'b0000; if4.handshake = 1'b0;
        tick();

        // 5: lock on m1, then a reset pulse clears the grant immediately.
        if4.req = 4'b0010;
        #2; check("t5_m1", int'(if4.grant), 4'b0010);
        tick();
        #1; check("t5_locked", int'(if4.grant), 4'b0010);
        rst4_n = 1'b0;
        #1; check("t5_rst_grant", int'(if4.grant), 0);
        check("t5_rst_valid", int'(if4.grant_valid), 0);
        if4.req = 4'b0000;
        #4; rst4_n = 1'b1;
        tick();
        if4.req = 4'b0011;
        #2; check("t5_after_rst", int'(if4.grant), 4'b0001);
        if4.handshake = 1'b1;
        tick();
        if4.req = 4'b0000; if4.handshake = 1'b0;
        tick();

        // 6: non-locking 3-master arbiter follows req with no handshake.
        if3.req = 3'b010;
        #2; check("t6_m1", int'(if3.grant), 3'b010);
        tick();
        if3.req = 3'b001;
        #2; check("t6_follow_m0", int'(if3.grant), 3'b001);
        tick();
        if3.req = 3'b010;
        #2; check("t6_back_m1", int'(if3.grant_idx), 1);
        tick();
        if3.req = 3'b111; if3.handshake = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("t6_idx%0d", i), int'(if3.grant_idx), seq6[i]);
            tick();
        end
        if3.req = 3'b000; if3.handshake = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
